core_sequencer: RTL and testbench
=================================

// Module: core_sequencer
// PURPOSE
//  Run/step/halt controller for the reduced single-cycle RISC-V core.
//  - Fetches each instruction over a req/ready handshake with instruction memory.
//  - Gates the PC update and the register-file write so one instruction commits per EXEC cycle.
//  - Stops on a halt opcode, on a stop request, or on a fetch timeout.
//  - Sits between top-level control, instrmem and the pc/register/regfile enables.
// PARAMETERS
//  WIDTH      32            instruction / PC width
//  CNT_W      32            width of retired-instruction counter
//  TIMEOUT    15            max cycles in FETCH without imem_ready before fault (>=1)
//  HALT_INSTR 32'h00100073  opcode that halts the core (ebreak)
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous, active-low reset
//  start        in   1      begin free-run from IDLE (pulse or level)
//  step         in   1      execute exactly one instruction from IDLE
//  stop         in   1      request return to IDLE at next instruction boundary
//  imem_ready   in   1      instruction memory has valid data this cycle
//  imem_rdata   in   WIDTH  instruction data, valid when imem_ready
//  imem_req     out  1      fetch request to instruction memory
//  instr_q      out  WIDTH  latched instruction driving decode/datapath
//  pc_en        out  1      PC register update enable (one cycle per commit)
//  regwrite_en  out  1      AND-mask for control unit RegWrite
//  busy         out  1      state is FETCH or EXEC
//  halted       out  1      HALT_INSTR seen; sticky until reset
//  fault        out  1      fetch timeout; sticky until reset
//  instr_count  out  CNT_W  retired instructions, saturating
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE; all outputs 0; instr_q=0; run_mode, stop_pend, wait_cnt cleared.
//  - States: IDLE, FETCH, EXEC, HALT, FAULT. All outputs are registered or decoded from state only.
//  - IDLE:
//    - start=1 -> FETCH with run_mode=1.
//    - else step=1 -> FETCH with run_mode=0.
//    - start and step together: start wins.
//    - stop is ignored in IDLE.
//  - FETCH: imem_req=1; wait_cnt increments each cycle imem_ready=0.
//    - imem_ready=1: instr_q<=imem_rdata and wait_cnt<=0.
//      - imem_rdata==HALT_INSTR -> HALT.
//      - otherwise -> EXEC.
//    - imem_ready=0 and stop_pend (or stop this cycle) -> IDLE; fetch is abandoned.
//    - imem_ready=0 and wait_cnt reaches TIMEOUT-1 -> FAULT.
//    - stop and imem_ready in the same cycle: the fetch completes and the instruction executes.
//  - EXEC: exactly one cycle; pc_en=1, regwrite_en=1; instr_count+1, saturating at all-ones.
//    - Next state is FETCH if run_mode=1 and neither stop_pend nor stop is set; otherwise IDLE.
//    - stop_pend is cleared on entering IDLE.
//  - stop_pend is set by stop in FETCH/EXEC and held until IDLE.
//  - start/step are ignored outside IDLE.
//  - HALT: halted=1, imem_req=0, pc_en=0; the halt opcode is never committed; exit only via reset.
//  - FAULT: fault=1, all enables 0; exit only via reset.
//  - Fetch latency is 1 cycle when imem_ready is high on FETCH entry, giving 2 cycles per instruction.
//  - Reset mid-fetch or mid-EXEC drops all enables asynchronously; no partial commit.
// CONFIGURATION
//  BREAKPOINT_EN (macro) defined:
//    - Adds ports pc (in, WIDTH), bp_addr (in, WIDTH), bp_valid (in, 1), bp_hit (out, 1).
//    - In FETCH with imem_ready=1, bp_valid=1 and pc==bp_addr: go to IDLE without executing.
//    - bp_hit=1 from that point until the next start or step.
//    - The breakpoint is not checked for the first fetch after a start or step, so resuming always progresses.
//  BREAKPOINT_EN undefined: none of these ports or logic exist; behaviour is exactly as above.
// TESTING
//  - Reset, then start=1 for 1 cycle, imem_ready=1 always, 3 non-halt instrs then 0x00100073
//    -> pc_en pulses 3 times, 2 cycles apart; instr_count=3; halted=1; imem_req=0.
//  - step=1 in IDLE with imem_ready=1 -> exactly one pc_en pulse, then IDLE; instr_count=1; busy=0.
//  - Run mode, imem_ready held 0 for TIMEOUT=15 cycles
//    -> fault=1 on cycle 15 of FETCH; no pc_en; fault held until rst=0.
//  - Running, stop asserted during EXEC -> that instruction commits; next state IDLE; imem_req=0.
//  - Stop asserted together with imem_ready in FETCH -> one further pc_en pulse, then IDLE.
//  - BREAKPOINT_EN: bp_addr=0x8, bp_valid=1, start from pc=0 -> commits at pc 0x0 and 0x4, stops with bp_hit=1;
//    a second start commits 0x8 and continues.

Source files
------------

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - run/step/halt sequencer for the single-cycle RISC-V core
// Optional breakpoint support is compiled in with the BREAKPOINT_EN macro.
module core_sequencer #(
    parameter int                 WIDTH      = 32,
    parameter int                 CNT_W      = 32,
    parameter int                 TIMEOUT    = 15,
    parameter logic [WIDTH-1:0]   HALT_INSTR = WIDTH'(32'h00100073)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step,
    input  logic              stop,
    input  logic              imem_ready,
    input  logic [WIDTH-1:0]  imem_rdata,
    output logic              imem_req,
    output logic [WIDTH-1:0]  instr_q,
    output logic              pc_en,
    output logic              regwrite_en,
    output logic              busy,
    output logic              halted,
    output logic              fault,
    output logic [CNT_W-1:0]  instr_count
`ifdef BREAKPOINT_EN
    ,
    input  logic [WIDTH-1:0]  pc,
    input  logic [WIDTH-1:0]  bp_addr,
    input  logic              bp_valid,
    output logic              bp_hit
`endif
);

    localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT, S_FAULT} state_t;

    state_t            state_q, state_d;
    logic              run_mode_q, run_mode_d;
    logic              stop_pend_q, stop_pend_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [WIDTH-1:0]  instr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bp_stop;

`ifdef BREAKPOINT_EN
    logic bp_hit_q, bp_hit_d;
    logic bp_skip_q, bp_skip_d;

    // The first fetch after a start/step skips the compare so a resume always moves past the breakpoint.
    assign bp_stop = bp_valid && (pc == bp_addr) && !bp_skip_q;
    assign bp_hit  = bp_hit_q;

    always_comb begin
        bp_hit_d  = bp_hit_q;
        bp_skip_d = bp_skip_q;
        if (state_q == S_IDLE && (start || step)) begin
            bp_hit_d  = 1'b0;
            bp_skip_d = 1'b1;
        end else if (state_q == S_FETCH && imem_ready) begin
            if (bp_stop) bp_hit_d = 1'b1;
            bp_skip_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bp_hit_q  <= 1'b0;
            bp_skip_q <= 1'b0;
        end else begin
            bp_hit_q  <= bp_hit_d;
            bp_skip_q <= bp_skip_d;
        end
    end
`else
    assign bp_stop = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        run_mode_d  = run_mode_q;
        stop_pend_d = stop_pend_q;
        wait_cnt_d  = wait_cnt_q;
        instr_d     = instr_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                stop_pend_d = 1'b0;
                wait_cnt_d  = '0;
                if (start) begin
                    state_d    = S_FETCH;
                    run_mode_d = 1'b1;
                end else if (step) begin
                    state_d    = S_FETCH;
                    run_mode_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (stop) stop_pend_d = 1'b1;
                if (imem_ready) begin
                    wait_cnt_d = '0;
                    if (bp_stop) begin
                        state_d     = S_IDLE;
                        stop_pend_d = 1'b0;
                    end else begin
                        instr_d = imem_rdata;
                        state_d = (imem_rdata == HALT_INSTR) ? S_HALT : S_EXEC;
                    end
                end else if (stop_pend_q || stop) begin
                    // Abandon the outstanding fetch; nothing has been committed yet.
                    state_d     = S_IDLE;
                    stop_pend_d = 1'b0;
                    wait_cnt_d  = '0;
                end else if (wait_cnt_q == WC_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end
            end
            S_EXEC: begin
                if (!(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
                if (run_mode_q && !stop_pend_q && !stop) begin
                    state_d = S_FETCH;
                end else begin
                    state_d     = S_IDLE;
                    stop_pend_d = 1'b0;
                end
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            run_mode_q  <= 1'b0;
            stop_pend_q <= 1'b0;
            wait_cnt_q  <= '0;
            instr_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            run_mode_q  <= run_mode_d;
            stop_pend_q <= stop_pend_d;
            wait_cnt_q  <= wait_cnt_d;
            instr_q     <= instr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign imem_req    = (state_q == S_FETCH);
    assign pc_en       = (state_q == S_EXEC);
    assign regwrite_en = (state_q == S_EXEC);
    assign busy        = (state_q == S_FETCH) || (state_q == S_EXEC);
    assign halted      = (state_q == S_HALT);
    assign fault       = (state_q == S_FAULT);
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - directed self-checking bench for core_sequencer
module tb_core_sequencer;

    localparam logic [31:0] HALT = 32'h00100073;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst, start, step, stop, imem_ready;
    logic [31:0] imem_rdata, instr_q;
    logic        imem_req, pc_en, regwrite_en, busy, halted, fault;
    logic [31:0] instr_count;
`ifdef BREAKPOINT_EN
    logic [31:0] pc = '0, bp_addr = '0;
    logic        bp_valid = 1'b0, bp_hit;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] prog [0:7];
    int idx;

    core_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .step(step), .stop(stop),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .imem_req(imem_req),
        .instr_q(instr_q), .pc_en(pc_en), .regwrite_en(regwrite_en), .busy(busy),
        .halted(halted), .fault(fault), .instr_count(instr_count)
`ifdef BREAKPOINT_EN
        , .pc(pc), .bp_addr(bp_addr), .bp_valid(bp_valid), .bp_hit(bp_hit)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory: next word is presented after each accepted fetch.
    always @(posedge clk or negedge rst) begin
        if (!rst) idx <= 0;
        else if (imem_req && imem_ready) idx <= idx + 1;
    end
    assign imem_rdata = prog[idx % 8];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; step = 1'b0; stop = 1'b0; imem_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, last, reqc;
        for (int i = 0; i < 8; i++) prog[i] = NOP;

        // Reset values and basic free-run to a halt opcode
        prog[0] = 32'h00500093; prog[1] = 32'h00a00113; prog[2] = 32'h002081b3; prog[3] = HALT;
        rst = 1'b0; start = 1'b0; step = 1'b0; stop = 1'b0; imem_ready = 1'b0;
        tick();
        check("rst_outs", {58'd0, busy, imem_req, pc_en, regwrite_en, halted, fault}, 64'd0);
        check("rst_instr_q", instr_q, 64'd0);
        check("rst_count", instr_count, 64'd0);
        rst = 1'b1; imem_ready = 1'b1;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        pulses = 0; last = 0;
        for (int c = 0; c < 30 && !halted; c++) begin
            if (pc_en) begin
                pulses++;
                check("t1_regwrite", regwrite_en, 1);
                if (pulses > 1) check("t1_gap", c - last, 2);
                last = c;
            end
            tick();
        end
        check("t1_halted", halted, 1);
        check("t1_pulses", pulses, 3);
        check("t1_count", instr_count, 3);
        check("t1_req", imem_req, 0);
        check("t1_instr_q", instr_q, HALT);
        start = 1'b1; tick(); start = 1'b0; tick();
        check("t1_halt_sticky", {halted, imem_req, pc_en}, 3'b100);
        prog[3] = NOP;

        // Single step
        do_reset();
        imem_ready = 1'b1;
        step = 1'b1; tick(); step = 1'b0;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            if (pc_en) pulses++;
            tick();
        end
        check("t2_pulses", pulses, 1);
        check("t2_count", instr_count, 1);
        check("t2_busy", busy, 0);
        check("t2_req", imem_req, 0);

        // Fetch timeout
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        reqc = 0; pulses = 0;
        for (int c = 0; c < 40 && !fault; c++) begin
            if (imem_req) reqc++;
            if (pc_en) pulses++;
            tick();
        end
        check("t3_fault", fault, 1);
        check("t3_fetch_cycles", reqc, 15);
        check("t3_no_commit", pulses, 0);
        imem_ready = 1'b1;
        repeat (5) tick();
        check("t3_fault_held", {fault, imem_req, busy, pc_en}, 4'b1000);
        rst = 1'b0; #1;
        check("t3_async_clear", fault, 0);

        // Stop during EXEC: that instruction commits, then IDLE
        do_reset();
        imem_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        pulses = 0;
        for (int c = 0; c < 20 && pulses < 2; c++) begin
            if (pc_en) pulses++;
            if (pulses == 2) stop = 1'b1;
            tick();
            stop = 1'b0;
        end
        check("t4_req", imem_req, 0);
        check("t4_busy", busy, 0);
        check("t4_count", instr_count, 2);
        repeat (4) tick();
        check("t4_count_stable", instr_count, 2);

        // Stop together with imem_ready: one more commit
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        stop = 1'b1; imem_ready = 1'b1; tick(); stop = 1'b0; imem_ready = 1'b0;
        check("t5_exec", pc_en, 1);
        tick();
        check("t5_idle", {busy, imem_req}, 2'b00);
        check("t5_count", instr_count, 1);

        // Stop with no data abandons the fetch and clears the timeout
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        tick();
        stop = 1'b1; tick(); stop = 1'b0;
        check("t6_idle", {busy, fault}, 2'b00);
        repeat (20) tick();
        check("t6_no_fault", fault, 0);
        check("t6_count", instr_count, 0);
        imem_ready = 1'b1;
        step = 1'b1; tick(); step = 1'b0;
        repeat (6) tick();
        check("t6_step_count", instr_count, 1);

        // start and step together: start wins (free run)
        do_reset();
        imem_ready = 1'b1;
        start = 1'b1; step = 1'b1; tick(); start = 1'b0; step = 1'b0;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            if (pc_en) pulses++;
            tick();
        end
        check("t7_pulses", pulses, 3);
        check("t7_busy", busy, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
